// File: rtl/phase_sequencer_pkg.sv
// Shared constants for the phase sequencer: FSM state encoding and the
// eight instruction phase codes seen by the instruction controller.
package phase_sequencer_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned COUNT_W = 16;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    // Instruction phases
    localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] IDLE_PH    = 3'd3;
    localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] STORE      = 3'd7;

endpackage

// File: rtl/phase_sequencer_counter.sv
// 3-bit instruction phase register. clr forces INST_ADDR, en advances by
// one with natural 7->0 wrap; wrap flags that the advance retires STORE.
module phase_counter
    import phase_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap
);

    // Wrap is flagged on the advancing edge out of the last phase
    assign wrap = en && (phase == STORE);

    // Phase register: clear wins over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= INST_ADDR;
        end else if (clr) begin
            phase <= INST_ADDR;
        end else if (en) begin
            phase <= phase + 3'd1;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: IDLE/RUN/STEP/HALTED control FSM that drives
// the phase counter, stalls on pending memory accesses and counts retired
// instructions. All outputs are registers or decodes of the state register.
module phase_sequencer
    import phase_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               clear,
    input  logic               halt,
    input  logic               rd,
    input  logic               wr,
    input  logic               mem_ready,
    output logic [PHASE_W-1:0] phase,
    output logic               running,
    output logic               halted,
    output logic               instr_done,
    output logic [COUNT_W-1:0] instr_count
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       active;
    logic       stall;
    logic       advance;
    logic       phase_clr;
    logic       retire;

    assign active    = (state == ST_RUN) || (state == ST_STEP);
    assign stall     = (rd || wr) && !mem_ready;
    // Halt outranks both stall and retire: a halted cycle never advances
    assign advance   = active && !halt && !stall;
    assign phase_clr = (state == ST_IDLE) || ((state == ST_HALTED) && clear);

    assign running = active;
    assign halted  = (state == ST_HALTED);

    phase_counter u_phase_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_clr),
        .en    (advance),
        .phase (phase),
        .wrap  (retire)
    );

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end else if (step) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end
            end
            ST_STEP: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (retire) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                if (clear) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Retire pulse and retired-instruction counter (wraps modulo 2^16)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_done  <= 1'b0;
            instr_count <= '0;
        end else begin
            instr_done <= retire;
            if (retire) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

endmodule
